// File: rtl/conv_wb_pkg.sv
// Shared types and AXI constants for the conv output DDR writer.
package conv_wb_pkg;

    localparam int DESC_ADR_W = 32;

    localparam logic [2:0] AXSIZE_64B = 3'd6;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_t;

    typedef struct packed {
        logic [DESC_ADR_W-1:0] adr;
        logic [7:0]            len;
    } desc_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible on pop_data while not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, count;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = (AW+1)'(DEPTH) - count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/conv_out_ddr_writer.sv
// Buffers the conv output word stream, coalesces consecutive word addresses into
// AXI4 INCR bursts (max length, 4KB page and flush bounded) and writes them one at a time.
module conv_out_ddr_writer
    import conv_wb_pkg::*;
#(
    parameter int DATA_W          = 512,
    parameter int ADR_W           = 32,
    parameter int WORD_BYTES_2POW = 6,
    parameter int DFIFO_DEPTH     = 32,
    parameter int DESC_DEPTH      = 8,
    parameter int MAX_BURST       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [ADR_W-1:0]    in_adr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                flush,
    output logic                ddr_en,
    output logic [ADR_W-1:0]    m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                wr_idle,
    output logic                wr_err
);
    localparam int PAGE_BITS = 12 - WORD_BYTES_2POW;
    localparam int DF_CW     = $clog2(DFIFO_DEPTH) + 1;
    localparam int DS_CW     = $clog2(DESC_DEPTH) + 1;

    logic             dfifo_pop, dfifo_full, dfifo_empty;
    logic [DF_CW-1:0] dfifo_free;
    logic             desc_push, desc_pop, desc_full, desc_empty;
    logic [DS_CW-1:0] desc_free;
    desc_t            desc_in, desc_out;

    logic [ADR_W-1:0] run_adr, run_end, app_adr, app_end;
    logic [8:0]       run_len, app_len;
    logic             close_pend, accept, run_open, push_old, close_now;

    wr_state_t        state, state_n;
    logic [ADR_W-1:0] cur_adr;
    logic [7:0]       cur_len, beat_cnt;

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(DFIFO_DEPTH)) u_dfifo (
        .clk(clk), .reset(reset),
        .push(accept), .push_data(in_data),
        .pop(dfifo_pop), .pop_data(m_wdata),
        .full(dfifo_full), .empty(dfifo_empty), .free_cnt(dfifo_free)
    );

    sync_fifo_fwft #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc (
        .clk(clk), .reset(reset),
        .push(desc_push), .push_data(desc_in),
        .pop(desc_pop), .pop_data(desc_out),
        .full(desc_full), .empty(desc_empty), .free_cnt(desc_free)
    );

    // Two free slots: a word may already be in flight when the credit drops.
    assign ddr_en  = !reset && (dfifo_free >= DF_CW'(2)) && (desc_free >= DS_CW'(2));
    assign wr_idle = dfifo_empty && desc_empty && (run_len == '0) && (state == IDLE);

    // close_pend marks a run that must close but lost the single desc-push slot to a break.
    always_comb begin
        accept   = in_valid && !dfifo_full;
        run_open = (run_len != '0) && !close_pend;
        run_end  = run_adr + ADR_W'(run_len);
        push_old = close_pend || (accept && run_open && in_adr != run_end);
        app_adr  = run_adr;
        app_len  = run_len;
        if (accept) begin
            if (run_open && in_adr == run_end) begin
                app_len = run_len + 9'd1;
            end else begin
                app_adr = in_adr;
                app_len = 9'd1;
            end
        end else if (close_pend) begin
            app_len = '0;
        end
        app_end   = app_adr + ADR_W'(app_len);
        close_now = (app_len != '0) &&
                    (app_len == 9'(MAX_BURST) || app_end[PAGE_BITS-1:0] == '0 || flush);
        desc_push   = push_old || close_now;
        desc_in.adr = push_old ? DESC_ADR_W'(run_adr) : DESC_ADR_W'(app_adr);
        desc_in.len = push_old ? 8'(run_len - 9'd1) : 8'(app_len - 9'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_adr    <= '0;
            run_len    <= '0;
            close_pend <= 1'b0;
        end else begin
            run_adr    <= app_adr;
            run_len    <= (close_now && !push_old) ? '0 : app_len;
            close_pend <= push_old && close_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!desc_empty)          state_n = ADDR;
            ADDR:    if (m_awready)            state_n = DATA;
            DATA:    if (m_wready && m_wlast)  state_n = RESP;
            RESP:    if (m_bvalid)             state_n = IDLE;
            default:                           state_n = IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        desc_pop  = 1'b0;
        dfifo_pop = 1'b0;
        case (state)
            IDLE: desc_pop = !desc_empty;
            ADDR: m_awvalid = 1'b1;
            DATA: begin
                m_wvalid  = 1'b1;
                m_wlast   = (beat_cnt == cur_len);
                dfifo_pop = m_wready;
            end
            RESP: m_bready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_adr  <= '0;
            cur_len  <= '0;
            beat_cnt <= '0;
            wr_err   <= 1'b0;
        end else begin
            if (desc_pop) begin
                cur_adr <= ADR_W'(desc_out.adr);
                cur_len <= desc_out.len;
            end
            if (state == ADDR)  beat_cnt <= '0;
            else if (dfifo_pop) beat_cnt <= beat_cnt + 8'd1;
            if (state == RESP && m_bvalid && m_bresp != 2'b00) wr_err <= 1'b1;
        end
    end

    assign m_awaddr  = cur_adr << WORD_BYTES_2POW;
    assign m_awlen   = cur_len;
    assign m_awsize  = AXSIZE_64B;
    assign m_awburst = BURST_INCR;
    assign m_wstrb   = '1;

    a_in_overflow:    assert property (@(posedge clk) disable iff (reset) !(in_valid && dfifo_full));
    a_desc_overflow:  assert property (@(posedge clk) disable iff (reset) !(desc_push && desc_full));
    a_data_underflow: assert property (@(posedge clk) disable iff (reset) !(state == DATA && dfifo_empty));

endmodule
